crypt_engine: RTL and testbench

Parametrised, iterative round-based encrypt/decrypt engine with a valid/ready handshake on both sides; successor to the fixed-width 60→76-bit Solver path. One `in_mode` bit selects the direction. Encryption prepends an internally generated LFSR nonce to the ciphertext. Decryption consumes `{nonce, cipher}` and returns the plaintext. Sits between the password/key source and the channel-side framing logic; one transaction is in flight at a time, one round per clock.

---
 rtl/crypt_pkg.sv | 40 ++++
 rtl/nonce_lfsr.sv | 22 ++
 rtl/crypt_engine.sv | 152 +++++++++++++++
 tb/tb_crypt_engine.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crypt_pkg.sv
// Shared definitions for the round-based crypt engine: modes, FSM states
// and width-generic rotate helpers (width passed as an argument, <= MAX_W).
package crypt_pkg;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int unsigned MAX_W = 128;
  typedef logic [MAX_W-1:0] word_t;

  function automatic word_t rotl(
    word_t       x,
    int unsigned w,
    int unsigned amt
  );
    word_t       m;
    word_t       v;
    int unsigned a;
    m = (w >= MAX_W) ? '1 : ((word_t'(1) << w) - word_t'(1));
    v = x & m;
    a = amt % w;
    // a == 0 shifts right by w, which yields zero for a masked value
    return ((v << a) | (v >> (w - a))) & m;
  endfunction

  function automatic word_t rotr(
    word_t       x,
    int unsigned w,
    int unsigned amt
  );
    return rotl(x, w, w - (amt % w));
  endfunction

endpackage

// File: rtl/nonce_lfsr.sv
// Free-running Galois LFSR; steps every cycle, held at SEED in reset.
module nonce_lfsr
  #(
    parameter int           W    = 16,
    parameter logic [W-1:0] TAPS = 'hB400,
    parameter logic [W-1:0] SEED = 'hACE1
  )
  (
    input  logic         Clk,
    input  logic         Rst,
    output logic [W-1:0] value
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      value <= SEED;
    end else begin
      value <= (value >> 1) ^ (value[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/crypt_engine.sv
// Iterative encrypt/decrypt engine, one round per clock, one transaction
// in flight; encryption prepends the LFSR nonce to the ciphertext.
module crypt_engine
  import crypt_pkg::*;
  #(
    parameter int                 DATA_W    = 60,
    parameter int                 NONCE_W   = 16,
    parameter int                 ROUNDS    = 8,
    parameter int                 ROT       = 7,
    parameter logic [NONCE_W-1:0] LFSR_TAPS = 'hB400,
    parameter logic [NONCE_W-1:0] LFSR_SEED = 'hACE1
  )
  (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_mode,
    input  logic [DATA_W+NONCE_W-1:0] in_data,
    input  logic [DATA_W-1:0]         key,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_mode,
    output logic [DATA_W+NONCE_W-1:0] out_data
  );

  localparam int OUT_W = DATA_W + NONCE_W;
  localparam int RW    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [RW-1:0] LAST = RW'(ROUNDS - 1);

  function automatic logic [DATA_W-1:0] rl(
    logic [DATA_W-1:0] x,
    int unsigned       amt
  );
    return DATA_W'(rotl(word_t'(x), DATA_W, amt));
  endfunction

  function automatic logic [DATA_W-1:0] rr(
    logic [DATA_W-1:0] x,
    int unsigned       amt
  );
    return DATA_W'(rotr(word_t'(x), DATA_W, amt));
  endfunction

  state_t              state;
  state_t              state_next;
  logic                mode_q;
  logic [DATA_W-1:0]   s_q;
  logic [DATA_W-1:0]   rk_q;
  logic [NONCE_W-1:0]  n_q;
  logic [RW-1:0]       r_q;
  logic [NONCE_W-1:0]  lfsr;
  logic [NONCE_W-1:0]  n_sel;
  logic [DATA_W-1:0]   rep;
  logic [DATA_W-1:0]   ke;
  logic [DATA_W-1:0]   rk_init;
  logic [DATA_W-1:0]   s_next;
  logic [DATA_W-1:0]   rk_next;
  logic                accept;
  logic                last;

  nonce_lfsr #(
    .W    (NONCE_W),
    .TAPS (LFSR_TAPS),
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .Clk   (Clk),
    .Rst   (Rst),
    .value (lfsr)
  );

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign last     = (r_q == LAST);

  assign n_sel = (in_mode == MODE_DEC) ? in_data[OUT_W-1:DATA_W] : lfsr;

  for (genvar i = 0; i < DATA_W; i++) begin : g_rep
    assign rep[i] = n_sel[i % NONCE_W];
  end

  assign ke = key ^ rep;

  // The round key register walks by one bit per round; decrypt starts
  // from the last encrypt round key and walks backwards.
  assign rk_init = (in_mode == MODE_DEC) ? rl(ke, (ROUNDS - 1) % DATA_W) : ke;

  always_comb begin
    s_next  = s_q;
    rk_next = rk_q;
    if (mode_q == MODE_DEC) begin
      s_next  = rr(s_q, ROT) ^ rk_q;
      rk_next = rr(rk_q, 1);
    end else begin
      s_next  = rl(s_q ^ rk_q, ROT);
      rk_next = rl(rk_q, 1);
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (accept)    state_next = ST_RUN;
      ST_RUN:  if (last)      state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mode_q <= MODE_ENC;
      s_q    <= '0;
      rk_q   <= '0;
      n_q    <= '0;
      r_q    <= '0;
    end else if (accept) begin
      mode_q <= in_mode;
      s_q    <= in_data[DATA_W-1:0];
      rk_q   <= rk_init;
      n_q    <= n_sel;
      r_q    <= '0;
    end else if (state == ST_RUN) begin
      s_q  <= s_next;
      rk_q <= rk_next;
      r_q  <= last ? '0 : r_q + RW'(1);
    end
  end

  assign out_valid = (state == ST_DONE);
  assign out_mode  = out_valid ? mode_q : MODE_ENC;

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      if (mode_q == MODE_DEC) begin
        out_data = {{NONCE_W{1'b0}}, s_q};
      end else begin
        out_data = {n_q, s_q};
      end
    end
  end

endmodule

// File: tb/tb_crypt_engine.sv
// Directed + randomized bench for crypt_engine against a behavioural
// model; one default-parameter instance and one tiny 8/4-bit instance.
module tb_crypt_engine;

  logic        clk;
  logic        rst;

  logic        in_valid;
  logic        in_ready;
  logic        in_mode;
  logic [75:0] in_data;
  logic [59:0] key;
  logic        out_valid;
  logic        out_ready;
  logic        out_mode;
  logic [75:0] out_data;

  logic        in_valid_s;
  logic        in_ready_s;
  logic        in_mode_s;
  logic [11:0] in_data_s;
  logic [7:0]  key_s;
  logic        out_valid_s;
  logic        out_ready_s;
  logic        out_mode_s;
  logic [11:0] out_data_s;

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_lfsr;

  crypt_engine dut (
    .Clk       (clk),
    .Rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mode  (out_mode),
    .out_data  (out_data)
  );

  crypt_engine #(
    .DATA_W    (8),
    .NONCE_W   (4),
    .ROUNDS    (1),
    .ROT       (1),
    .LFSR_TAPS (4'hC),
    .LFSR_SEED (4'h1)
  ) dut_s (
    .Clk       (clk),
    .Rst       (rst),
    .in_valid  (in_valid_s),
    .in_ready  (in_ready_s),
    .in_mode   (in_mode_s),
    .in_data   (in_data_s),
    .key       (key_s),
    .out_valid (out_valid_s),
    .out_ready (out_ready_s),
    .out_mode  (out_mode_s),
    .out_data  (out_data_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference nonce source: the step rule applied to a plain variable.
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  function automatic logic [59:0] rl60(logic [59:0] x, int a);
    logic [119:0] d;
    d = {x, x} << (a % 60);
    return d[119:60];
  endfunction

  function automatic logic [75:0] model_enc(
    logic [59:0] p,
    logic [59:0] k,
    logic [15:0] n
  );
    logic [59:0] ke;
    logic [59:0] s;
    for (int i = 0; i < 60; i++) ke[i] = k[i] ^ n[i % 16];
    s = p;
    for (int r = 0; r < 8; r++) s = rl60(s ^ rl60(ke, r), 7);
    return {n, s};
  endfunction

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
  endtask

  // Starts and ends at a negedge with the default instance idle.
  task automatic run_txn(
    input  logic        mode,
    input  logic [75:0] data,
    input  logic [59:0] k,
    output logic [75:0] res,
    output logic        rmode,
    output logic [15:0] nonce,
    output int          lat
  );
    check("in_ready_idle", 128'(in_ready), 128'(1));
    nonce    = m_lfsr;
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = data;
    key      = k;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 76'({$urandom(), $urandom(), $urandom()});
    key      = 60'({$urandom(), $urandom()});
    wait_done(lat);
    res   = out_data;
    rmode = out_mode;
    pop();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [75:0] res;
    logic [75:0] res2;
    logic [75:0] hold;
    logic        rmode;
    logic [15:0] nonce;
    logic [15:0] nonce2;
    logic [59:0] p;
    logic [59:0] k;
    logic [59:0] p2;
    logic [59:0] k2;
    int          lat;
    int          seen;

    rst         = 1'b1;
    in_valid    = 1'b0;
    in_mode     = 1'b0;
    in_data     = '0;
    key         = '0;
    out_ready   = 1'b0;
    in_valid_s  = 1'b0;
    in_mode_s   = 1'b0;
    in_data_s   = '0;
    key_s       = '0;
    out_ready_s = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_data", 128'(out_data), 128'(0));
    check("rst_out_mode", 128'(out_mode), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_lfsr", 128'(dut.u_lfsr.value), 128'(16'hACE1));
    check("rst_s_out_valid", 128'(out_valid_s), 128'(0));
    check("rst_s_out_data", 128'(out_data_s), 128'(0));

    // Tiny config: encrypt accepted at the first edge after release
    rst        = 1'b0;
    in_valid_s = 1'b1;
    in_mode_s  = 1'b0;
    in_data_s  = 12'h001;
    key_s      = 8'h00;
    check("s_in_ready", 128'(in_ready_s), 128'(1));
    check("lfsr_t0", 128'(dut.u_lfsr.value), 128'(16'hACE1));
    @(posedge clk);
    #1 in_valid_s = 1'b0;
    @(negedge clk);
    check("lfsr_t1", 128'(dut.u_lfsr.value), 128'(16'hE270));
    check("s_run_no_valid", 128'(out_valid_s), 128'(0));
    @(posedge clk);
    @(negedge clk);
    check("s_enc_valid", 128'(out_valid_s), 128'(1));
    check("s_enc_data", 128'(out_data_s), 128'(12'h120));
    check("s_enc_mode", 128'(out_mode_s), 128'(0));
    out_ready_s = 1'b1;
    @(posedge clk);
    #1 out_ready_s = 1'b0;
    @(negedge clk);
    check("s_pop_valid", 128'(out_valid_s), 128'(0));
    check("s_pop_ready", 128'(in_ready_s), 128'(1));

    in_valid_s = 1'b1;
    in_mode_s  = 1'b1;
    in_data_s  = 12'h120;
    key_s      = 8'h00;
    @(posedge clk);
    #1 in_valid_s = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("s_dec_valid", 128'(out_valid_s), 128'(1));
    check("s_dec_data", 128'(out_data_s), 128'(12'h001));
    check("s_dec_mode", 128'(out_mode_s), 128'(1));
    out_ready_s = 1'b1;
    @(posedge clk);
    #1 out_ready_s = 1'b0;
    @(negedge clk);

    // Random encrypt -> decrypt round trips
    for (int t = 0; t < 200; t++) begin
      p = 60'({$urandom(), $urandom()});
      k = 60'({$urandom(), $urandom()});
      run_txn(1'b0, {16'($urandom()), p}, k, res, rmode, nonce, lat);
      check("enc_data", 128'(res), 128'(model_enc(p, k, nonce)));
      check("enc_mode", 128'(rmode), 128'(0));
      check("enc_lat", 128'(lat), 128'(8));
      run_txn(1'b1, res, k, res2, rmode, nonce2, lat);
      check("dec_data", 128'(res2), 128'({16'h0000, p}));
      check("dec_mode", 128'(rmode), 128'(1));
      check("dec_lat", 128'(lat), 128'(8));
    end

    // Backpressure with a second request waiting during DONE
    p        = 60'({$urandom(), $urandom()});
    k        = 60'({$urandom(), $urandom()});
    nonce    = m_lfsr;
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_data  = {16'h0, p};
    key      = k;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_done(lat);
    hold = out_data;
    check("bp_first_data", 128'(hold), 128'(model_enc(p, k, nonce)));
    p2       = 60'({$urandom(), $urandom()});
    k2       = 60'({$urandom(), $urandom()});
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_data  = {16'h0, p2};
    key      = k2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_data", 128'(out_data), 128'(hold));
      check("bp_hold_valid", 128'(out_valid), 128'(1));
      check("bp_hold_in_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp_pop_valid", 128'(out_valid), 128'(0));
    check("bp_pop_in_ready", 128'(in_ready), 128'(1));
    nonce2 = m_lfsr;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_done(lat);
    check("bp_second_lat", 128'(lat), 128'(8));
    check("bp_second_data", 128'(out_data), 128'(model_enc(p2, k2, nonce2)));
    pop();

    // Reset in the middle of a transaction
    p        = 60'({$urandom(), $urandom()});
    k        = 60'({$urandom(), $urandom()});
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_data  = {16'h0, p};
    key      = k;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 128'(out_valid), 128'(0));
    check("mid_rst_in_ready", 128'(in_ready), 128'(1));
    check("mid_rst_data", 128'(out_data), 128'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_lfsr", 128'(dut.u_lfsr.value), 128'(16'hACE1));
      check("mid_rst_hold_valid", 128'(out_valid), 128'(0));
    end
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("post_rst_no_result", 128'(seen), 128'(0));
    check("post_rst_in_ready", 128'(in_ready), 128'(1));

    p = 60'({$urandom(), $urandom()});
    k = 60'({$urandom(), $urandom()});
    run_txn(1'b0, {16'h0, p}, k, res, rmode, nonce, lat);
    check("post_rst_enc", 128'(res), 128'(model_enc(p, k, nonce)));
    check("post_rst_lat", 128'(lat), 128'(8));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
